// File: rtl/mc_pkg.sv
// Shared types and select codes for the multicycle ARM sequencing FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_BASEWB = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10
  } mc_state_t;

  // Instruction classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Address mux
  localparam logic [1:0] ADR_PC     = 2'd0;
  localparam logic [1:0] ADR_ALUOUT = 2'd1;
  localparam logic [1:0] ADR_RN     = 2'd2;

  // ALU B operand mux
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_RDATA  = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  // Immediate extension, shared with the instruction decoder
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  // Moore output vector; the *_en fields are gated with mem_ready/reset at the top
  typedef struct packed {
    logic       fetch_en;
    logic       branch_pc;
    logic       store_en;
    logic       reg_w;
    logic       wb_base;
    logic [1:0] adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic [1:0] imm_src;
  } mc_ctrl_t;

  // Post-indexed accesses use the unmodified base register as the address
  function automatic logic [1:0] mem_adr_sel(input logic post_idx);
    return post_idx ? ADR_RN : ADR_ALUOUT;
  endfunction

endpackage

// File: rtl/mc_output_rom.sv
// State-to-control mapping for the multicycle controller (pure combinational).
module mc_output_rom
  import mc_pkg::*;
(
  input  mc_state_t i_state,
  input  logic      i_reg_off,
  input  logic      i_post_idx,
  output mc_ctrl_t  o_ctrl
);

  // Decode the current state into datapath selects and raw enables
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.fetch_en   = 1'b1;
        o_ctrl.adr_src    = ADR_PC;
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALU;
      end
      S_EXECR: begin
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = 1'b1;
        o_ctrl.imm_src   = IMM_DP;
      end
      S_EXECI: begin
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = 1'b1;
        o_ctrl.imm_src   = IMM_DP;
      end
      S_ALUWB: begin
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.reg_w      = 1'b1;
      end
      S_MEMADR: begin
        o_ctrl.alu_src_b = i_reg_off ? SRCB_REG : SRCB_IMM;
        o_ctrl.imm_src   = IMM_MEM;
      end
      S_MEMRD: begin
        o_ctrl.adr_src = mem_adr_sel(i_post_idx);
      end
      S_MEMWR: begin
        o_ctrl.adr_src  = mem_adr_sel(i_post_idx);
        o_ctrl.store_en = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.result_src = RES_RDATA;
        o_ctrl.reg_w      = 1'b1;
      end
      S_BASEWB: begin
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.reg_w      = 1'b1;
        o_ctrl.wb_base    = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_b  = SRCB_IMM;
        o_ctrl.imm_src    = IMM_BR;
        o_ctrl.result_src = RES_ALU;
        o_ctrl.branch_pc  = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle ARM core: state register, next-state
// logic and the mem_ready/reset gating of the write enables.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic       cond_ex,
  input  logic       mem_ready,
  output logic       ir_w,
  output logic       pc_w,
  output logic       mem_w,
  output logic       reg_w,
  output logic       wb_base,
  output logic [1:0] adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic [1:0] imm_src,
  output logic       illegal
);

  mc_state_t r_state;
  mc_state_t w_next;
  mc_ctrl_t  w_ctrl;
  logic      w_post_idx;
  logic      w_illegal;
  logic      w_en;
  logic      w_unused_funct;

  assign w_post_idx     = ~funct[4];
  assign w_unused_funct = ^funct[3:1];

  // State register; reset drops the FSM straight back into FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state selection and the illegal-opcode pulse
  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!cond_ex) begin
          w_next = S_FETCH;
        end else begin
          case (op)
            OP_DP:   w_next = funct[5] ? S_EXECI : S_EXECR;
            OP_MEM:  w_next = S_MEMADR;
            OP_BR:   w_next = S_BRANCH;
            default: begin
              w_next    = S_FETCH;
              w_illegal = 1'b1;
            end
          endcase
        end
      end
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_MEMADR: w_next = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = w_post_idx ? S_BASEWB : S_FETCH;
      S_MEMWR:  begin
        if (!mem_ready)      w_next = S_MEMWR;
        else if (w_post_idx) w_next = S_BASEWB;
        else                 w_next = S_FETCH;
      end
      S_BASEWB: w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  mc_output_rom u_rom (
    .i_state    (r_state),
    .i_reg_off  (funct[5]),
    .i_post_idx (w_post_idx),
    .o_ctrl     (w_ctrl)
  );

  // Enables are suppressed for as long as reset is held so no write leaks out
  assign w_en       = ~reset;
  assign ir_w       = w_en & w_ctrl.fetch_en & mem_ready;
  assign pc_w       = w_en & ((w_ctrl.fetch_en & mem_ready) | w_ctrl.branch_pc);
  assign mem_w      = w_en & w_ctrl.store_en & mem_ready;
  assign reg_w      = w_en & w_ctrl.reg_w;
  assign illegal    = w_en & w_illegal;
  assign wb_base    = w_ctrl.wb_base;
  assign adr_src    = w_ctrl.adr_src;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign result_src = w_ctrl.result_src;
  assign alu_op     = w_ctrl.alu_op;
  assign imm_src    = w_ctrl.imm_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction step plans
// built from the instruction rules, driven with directed and random stalls.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic       cond_ex = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_w, pc_w, mem_w, reg_w, wb_base, alu_src_a, alu_op, illegal;
  logic [1:0] adr_src, alu_src_b, result_src, imm_src;

  int n_vec = 0;
  int n_mis = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .cond_ex(cond_ex),
    .mem_ready(mem_ready), .ir_w(ir_w), .pc_w(pc_w), .mem_w(mem_w),
    .reg_w(reg_w), .wb_base(wb_base), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .imm_src(imm_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] w_obs;
  assign w_obs = {ir_w, pc_w, mem_w, reg_w, wb_base, adr_src, alu_src_a,
                  alu_src_b, result_src, alu_op, imm_src, illegal};

  // One cycle of an instruction as seen from outside the controller
  typedef struct packed {
    logic       gf;     // ir_w/pc_w follow mem_ready
    logic       gs;     // mem_w follows mem_ready
    logic       br_pc;  // unconditional PC load
    logic       reg_w;
    logic       wb_base;
    logic [1:0] adr;
    logic       a;
    logic [1:0] b;
    logic [1:0] res;
    logic       aluop;
    logic [1:0] imm;
    logic       illg;
    logic       waits;  // step repeats while mem_ready is low
  } step_t;

  step_t       plan[$];
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [1:0]  cur_op;
  logic [5:0]  cur_funct;
  logic        cur_cond;

  function automatic step_t mk_fetch();
    step_t s;
    s = '0; s.gf = 1'b1; s.a = 1'b1; s.b = 2'd2; s.res = 2'd2; s.waits = 1'b1;
    return s;
  endfunction

  function automatic step_t mk_decode(input logic [1:0] o, input logic c);
    step_t s;
    s = '0; s.a = 1'b1; s.b = 2'd2; s.res = 2'd2;
    s.illg = c && (o == 2'b11);
    return s;
  endfunction

  function automatic logic [15:0] expect_vec(input step_t s, input logic rdy, input logic rst);
    logic en;
    en = ~rst;
    return {s.gf & rdy & en, ((s.gf & rdy) | s.br_pc) & en, s.gs & rdy & en,
            s.reg_w & en, s.wb_base, s.adr, s.a, s.b, s.res, s.aluop, s.imm,
            s.illg & en};
  endfunction

  function automatic void build_plan(input logic [1:0] o, input logic [5:0] f, input logic c);
    step_t s;
    logic  post;
    post = ~f[4];
    plan.delete();
    plan.push_back(mk_fetch());
    plan.push_back(mk_decode(o, c));
    if (c && o != 2'b11) begin
      if (o == 2'b00) begin
        s = '0; s.b = f[5] ? 2'd1 : 2'd0; s.aluop = 1'b1; plan.push_back(s);
        s = '0; s.res = 2'd0; s.reg_w = 1'b1; plan.push_back(s);
      end else if (o == 2'b01) begin
        s = '0; s.b = f[5] ? 2'd0 : 2'd1; s.imm = 2'b01; plan.push_back(s);
        if (f[0]) begin
          s = '0; s.adr = post ? 2'd2 : 2'd1; s.waits = 1'b1; plan.push_back(s);
          s = '0; s.res = 2'd1; s.reg_w = 1'b1; plan.push_back(s);
        end else begin
          s = '0; s.adr = post ? 2'd2 : 2'd1; s.gs = 1'b1; s.waits = 1'b1; plan.push_back(s);
        end
        if (post) begin
          s = '0; s.res = 2'd0; s.reg_w = 1'b1; s.wb_base = 1'b1; plan.push_back(s);
        end
      end else begin
        s = '0; s.b = 2'd1; s.imm = 2'b10; s.res = 2'd2; s.br_pc = 1'b1; plan.push_back(s);
      end
    end
  endfunction

  task automatic set_instr(input logic [1:0] o, input logic [5:0] f, input logic c);
    cur_op = o; cur_funct = f; cur_cond = c;
    build_plan(o, f, c);
  endtask

  // Drives the current plan; records observed and expected vectors per cycle
  task automatic run_plan(input int stall_idx, input int stall_n, input bit rnd, output int cycles);
    int   idx;
    int   cnt;
    logic rdy;
    obs_q.delete(); exp_q.delete();
    idx = 0; cnt = 0; cycles = 0;
    while (idx < plan.size()) begin
      if (rnd) rdy = (cnt >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else     rdy = !(idx == stall_idx && cnt < stall_n);
      @(negedge clk);
      if (cycles == 0) begin
        op = cur_op; funct = cur_funct; cond_ex = cur_cond;
      end
      mem_ready = rdy;
      #2;
      obs_q.push_back(w_obs);
      exp_q.push_back(expect_vec(plan[idx], rdy, 1'b0));
      cycles++;
      if (plan[idx].waits && !rdy) cnt++;
      else begin idx++; cnt = 0; end
    end
  endtask

  task automatic test_reset();
    logic [15:0] e;
    @(negedge clk); mem_ready = 1'b1; #2;
    e = expect_vec(mk_fetch(), 1'b1, 1'b1);
    n_vec++;
    if (w_obs !== e) begin n_mis++; $display("FAIL reset_hold got=%h exp=%h", w_obs, e); end
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #2;
    e = expect_vec(mk_fetch(), 1'b0, 1'b0);
    n_vec++;
    if (w_obs !== e) begin n_mis++; $display("FAIL reset_release got=%h exp=%h", w_obs, e); end
  endtask

  task automatic test_dp();
    int cyc;
    logic [5:0] fs [2] = '{6'b001000, 6'b101000};
    for (int k = 0; k < 2; k++) begin
      set_instr(2'b00, fs[k], 1'b1);
      run_plan(-1, 0, 1'b0, cyc);
      for (int i = 0; i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_mis++; $display("FAIL dp[%0d] cyc%0d got=%h exp=%h", k, i, obs_q[i], exp_q[i]);
        end
      end
      n_vec++;
      if (cyc !== 4) begin n_mis++; $display("FAIL dp_cycles[%0d] got=%0d exp=4", k, cyc); end
    end
  endtask

  task automatic test_ldr();
    int cyc;
    set_instr(2'b01, 6'b000001, 1'b1);
    run_plan(3, 2, 1'b0, cyc);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mis++; $display("FAIL ldr_post cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (cyc !== 8) begin n_mis++; $display("FAIL ldr_post_cycles got=%0d exp=8", cyc); end
    set_instr(2'b01, 6'b011001, 1'b1);
    run_plan(-1, 0, 1'b0, cyc);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mis++; $display("FAIL ldr_pre cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (cyc !== 5) begin n_mis++; $display("FAIL ldr_pre_cycles got=%0d exp=5", cyc); end
  endtask

  task automatic test_str();
    int cyc;
    set_instr(2'b01, 6'b010000, 1'b1);
    run_plan(3, 3, 1'b0, cyc);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mis++; $display("FAIL str_imm cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (cyc !== 7) begin n_mis++; $display("FAIL str_imm_cycles got=%0d exp=7", cyc); end
    set_instr(2'b01, 6'b000000, 1'b1);
    run_plan(-1, 0, 1'b0, cyc);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mis++; $display("FAIL str_post cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (cyc !== 5) begin n_mis++; $display("FAIL str_post_cycles got=%0d exp=5", cyc); end
  endtask

  task automatic test_branch_illegal();
    int cyc;
    logic [1:0] os [3] = '{2'b10, 2'b10, 2'b11};
    logic       cs [3] = '{1'b0, 1'b1, 1'b1};
    int         ns [3] = '{2, 3, 2};
    for (int k = 0; k < 3; k++) begin
      set_instr(os[k], 6'b100000, cs[k]);
      run_plan(-1, 0, 1'b0, cyc);
      for (int i = 0; i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_mis++; $display("FAIL br_ill[%0d] cyc%0d got=%h exp=%h", k, i, obs_q[i], exp_q[i]);
        end
      end
      n_vec++;
      if (cyc !== ns[k]) begin n_mis++; $display("FAIL br_ill_cycles[%0d] got=%0d exp=%0d", k, cyc, ns[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [15:0] e;
    set_instr(2'b01, 6'b010000, 1'b1);
    while (plan.size() > 3) void'(plan.pop_back());
    run_plan(-1, 0, 1'b0, cyc);
    for (int i = 0; i < obs_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_mis++; $display("FAIL rst_mid_pre cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    n_vec++;
    if ({mem_w, adr_src} !== 3'b101) begin
      n_mis++; $display("FAIL rst_mid_memwr got=%b exp=101", {mem_w, adr_src});
    end
    reset = 1'b1; #1;
    e = expect_vec(mk_fetch(), 1'b1, 1'b1);
    n_vec++;
    if (w_obs !== e) begin n_mis++; $display("FAIL rst_mid_assert got=%h exp=%h", w_obs, e); end
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #2;
    e = expect_vec(mk_fetch(), 1'b0, 1'b0);
    n_vec++;
    if (w_obs !== e) begin n_mis++; $display("FAIL rst_mid_idle got=%h exp=%h", w_obs, e); end
    @(negedge clk); mem_ready = 1'b1; #2;
    e = expect_vec(mk_fetch(), 1'b1, 1'b0);
    n_vec++;
    if (w_obs !== e) begin n_mis++; $display("FAIL rst_mid_fetch got=%h exp=%h", w_obs, e); end
    @(negedge clk); cond_ex = 1'b0; #2;
    e = expect_vec(mk_decode(2'b01, 1'b0), 1'b1, 1'b0);
    n_vec++;
    if (w_obs !== e) begin n_mis++; $display("FAIL rst_mid_squash got=%h exp=%h", w_obs, e); end
  endtask

  task automatic test_random();
    int cyc;
    for (int k = 0; k < 80; k++) begin
      set_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), $urandom_range(0, 4) != 0);
      run_plan(-1, 0, 1'b1, cyc);
      for (int i = 0; i < obs_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_mis++;
          $display("FAIL rand[%0d] op=%b funct=%b cond=%b cyc%0d got=%h exp=%h",
                   k, cur_op, cur_funct, cur_cond, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dp();
    test_ldr();
    test_str();
    test_branch_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle ARM core. It steps the shared datapath (one ALU, one memory port, one register-file write port) through fetch, decode, execute, memory and write-back for data-processing, LDR/STR (including post-indexed base writeback) and B instructions. It sits beside the instruction-class decoder and drives all datapath enables and mux selects. It stalls on a memory ready handshake.

## Interface
Parameters:
- none (state encoding and select codes come from `mc_pkg`)

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `op`  in  2  instruction class: 00 DP, 01 memory, 10 branch, 11 illegal
- `funct`  in  6  instruction bits [25:20]
- `cond_ex`  in  1  condition check passed, valid in DECODE and later
- `mem_ready`  in  1  memory access completes this cycle
- `ir_w`  out  1  instruction register load
- `pc_w`  out  1  PC load
- `mem_w`  out  1  memory write strobe
- `reg_w`  out  1  register file write
- `wb_base`  out  1  write destination is Rn, not Rd
- `adr_src`  out  2  address select: 0 PC, 1 ALUOut, 2 Rn
- `alu_src_a`  out  1  0 register A, 1 PC
- `alu_src_b`  out  2  0 register B, 1 extended immediate, 2 constant 4
- `result_src`  out  2  0 ALUOut, 1 read data, 2 ALU result
- `alu_op`  out  1  ALU decodes funct (DP) vs. forced add
- `imm_src`  out  2  00 DP, 01 memory, 10 branch
- `illegal`  out  1  one-cycle pulse on op=11

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, BASEWB, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: adr_src=0, a=PC, b=4, result_src=2. ir_w=pc_w=mem_ready. Stays in FETCH while !mem_ready, otherwise goes to DECODE.
- DECODE: a=PC, b=4, result_src=2, no enables asserted.
  - cond_ex=0 goes to FETCH (instruction squashed).
  - op=11 pulses illegal and goes to FETCH.
  - op=00 goes to EXECI if funct[5] else EXECR.
  - op=01 goes to MEMADR.
  - op=10 goes to BRANCH.
- EXECR/EXECI: a=A, b=0 or 1, alu_op=1, imm_src=00. Next state ALUWB.
- ALUWB: result_src=0, reg_w=1. Next state FETCH.
- MEMADR: a=A, b = funct[5] ? 0 : 1, imm_src=01, alu_op=0. Next state is MEMRD if funct[0], else MEMWR.
- post_idx = ~funct[4]. In MEMRD/MEMWR, adr_src = post_idx ? 2 : 1.
- MEMRD: wait for mem_ready. Next state MEMWB.
- MEMWB: result_src=1, reg_w=1. Next state is BASEWB if post_idx, else FETCH.
- MEMWR: mem_w=mem_ready. On completion, next state is BASEWB if post_idx, else FETCH.
- BASEWB: result_src=0, reg_w=1, wb_base=1. Next state FETCH.
- BRANCH: a=A (R15 = PC+8), b=1, imm_src=10, result_src=2, pc_w=1. Next state FETCH.
- Any unreachable state encoding goes to FETCH.

## Timing
- Next-state logic is registered. Selects are Moore outputs of state.
- ir_w, pc_w (in FETCH) and mem_w depend combinationally on mem_ready.
- All write enables (ir_w, pc_w, mem_w, reg_w) are forced to 0 while reset is high.
- Reset values: state=FETCH, all enables and illegal =0, selects take their FETCH values.
- Zero-wait cycle counts (FETCH to next FETCH):
  - DP: 4
  - LDR: 5; LDR post-indexed: 6
  - STR: 4; STR post-indexed: 5
  - B: 3
  - squashed or illegal: 2
- Each !mem_ready cycle adds one cycle. The FSM holds its state, and selects stay stable throughout the stall.
- Reset asserted mid-instruction: returns to FETCH immediately. No partial write is issued after the reset edge.

## Structure
- `mc_pkg` holds:
  - `mc_state_t` enum
  - adr_src, alu_src_b and result_src code localparams
  - imm_src codes (shared with the decoder)
- One sub-module, `mc_output_rom`: combinational mapping from state to Moore output vector. Mealy gating stays in the top-level module.

## Test plan
- ADD reg, cond_ex=1, mem_ready=1 → states FETCH→DECODE→EXECR→ALUWB. reg_w=1 only in ALUWB. 4 cycles.
- LDR post-indexed (funct=6'b000001), mem_ready low for 2 cycles in MEMRD → adr_src=2 in MEMRD, MEMWB reg_w with result_src=1, then BASEWB wb_base=1. 8 cycles total.
- STR imm (funct=6'b010000), mem_ready low 3 cycles → mem_w asserted only in the ready cycle, adr_src=1, then FETCH.
- B with cond_ex=0 → DECODE goes to FETCH, pc_w never asserted outside FETCH. With cond_ex=1: pc_w=1 in BRANCH, imm_src=10.
- op=11 → illegal pulses exactly 1 cycle in DECODE, no enables asserted.
- Reset asserted during MEMWR with mem_ready=1 → mem_w drops at once. After release, state=FETCH and ir_w follows mem_ready.
